demultiplexer_1to16_reg: RTL and testbench

Registered 1-to-16 demultiplexer with valid/ready flow control: the write-side counterpart of the 16-to-1 result multiplexer in the ALU datapath. A single input word is steered by `sel` into one of 16 output holding registers. Each holding register presents its word on its own output port until that consumer accepts it. It distributes operands or results from one producer to the 16 per-operation lanes.

---
 rtl/mux_pkg.sv | 8 +
 rtl/demux_lane_reg.sv | 37 +++
 rtl/demultiplexer_1to16_reg.sv | 83 ++++++++
 tb/tb_demultiplexer_1to16_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the ALU result multiplexer and the operand/result demultiplexer.
package mux_pkg;

  localparam int SEL_WIDTH        = 4;
  localparam int NUM_LANES        = 1 << SEL_WIDTH;
  localparam int DEFAULT_IN_WIDTH = 32;

endpackage : mux_pkg

// File: rtl/demux_lane_reg.sv
// One demultiplexer lane: a holding register plus its valid flag (EMPTY/FULL).
module demux_lane_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic [W-1:0] data,
  output logic         valid
);

  logic [W-1:0] data_r;
  logic         valid_r;

  // Lane state: reset clears, a load wins over a concurrent drain, a drain only drops valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= {W{1'b0}};
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
    end else if (valid_r && out_ready) begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule : demux_lane_reg

// File: rtl/demultiplexer_1to16_reg.sv
// Registered 1-to-16 demultiplexer with per-lane valid/ready handshakes.
// The top only decodes sel into a one-hot load vector and muxes in_ready.
module demultiplexer_1to16_reg
  import mux_pkg::*;
#(
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IN_WIDTH-1:0]  out_0,
  output logic [IN_WIDTH-1:0]  out_1,
  output logic [IN_WIDTH-1:0]  out_2,
  output logic [IN_WIDTH-1:0]  out_3,
  output logic [IN_WIDTH-1:0]  out_4,
  output logic [IN_WIDTH-1:0]  out_5,
  output logic [IN_WIDTH-1:0]  out_6,
  output logic [IN_WIDTH-1:0]  out_7,
  output logic [IN_WIDTH-1:0]  out_8,
  output logic [IN_WIDTH-1:0]  out_9,
  output logic [IN_WIDTH-1:0]  out_10,
  output logic [IN_WIDTH-1:0]  out_11,
  output logic [IN_WIDTH-1:0]  out_12,
  output logic [IN_WIDTH-1:0]  out_13,
  output logic [IN_WIDTH-1:0]  out_14,
  output logic [IN_WIDTH-1:0]  out_15,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready
);

  logic [NUM_LANES-1:0] load_s;
  logic                 xfer_s;
  logic [IN_WIDTH-1:0]  lane_data_s [NUM_LANES];

  // Ready depends only on the targeted lane's state, never on in_valid.
  always_comb begin
    in_ready = !out_valid[sel] || out_ready[sel];
  end

  // One-hot load decode, gated by the accepted transfer.
  always_comb begin
    load_s = {NUM_LANES{1'b0}};
    xfer_s = in_valid && in_ready;
    if (xfer_s) begin
      load_s = {{(NUM_LANES-1){1'b0}}, 1'b1} << sel;
    end else begin
      load_s = {NUM_LANES{1'b0}};
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_reg #(.W(IN_WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s[i]),
      .load_data (in_data),
      .out_ready (out_ready[i]),
      .data      (lane_data_s[i]),
      .valid     (out_valid[i])
    );
  end

  assign out_0  = lane_data_s[0];
  assign out_1  = lane_data_s[1];
  assign out_2  = lane_data_s[2];
  assign out_3  = lane_data_s[3];
  assign out_4  = lane_data_s[4];
  assign out_5  = lane_data_s[5];
  assign out_6  = lane_data_s[6];
  assign out_7  = lane_data_s[7];
  assign out_8  = lane_data_s[8];
  assign out_9  = lane_data_s[9];
  assign out_10 = lane_data_s[10];
  assign out_11 = lane_data_s[11];
  assign out_12 = lane_data_s[12];
  assign out_13 = lane_data_s[13];
  assign out_14 = lane_data_s[14];
  assign out_15 = lane_data_s[15];

endmodule : demultiplexer_1to16_reg

// File: tb/tb_demultiplexer_1to16_reg.sv
// Directed plus randomized bench for demultiplexer_1to16_reg against a per-lane array model.
module tb_demultiplexer_1to16_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15;
  logic [31:0] outs [16];

  int total = 0;
  int bad   = 0;
  bit model_known = 1'b0;

  // Reference: each lane is just a stored word and a full flag.
  logic [31:0] m_data  [16];
  bit          m_full  [16];

  always #5 clk = ~clk;

  demultiplexer_1to16_reg dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_0(o0), .out_1(o1), .out_2(o2), .out_3(o3),
    .out_4(o4), .out_5(o5), .out_6(o6), .out_7(o7),
    .out_8(o8), .out_9(o9), .out_10(o10), .out_11(o11),
    .out_12(o12), .out_13(o13), .out_14(o14), .out_15(o15),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  assign outs[0] = o0;   assign outs[1] = o1;   assign outs[2] = o2;   assign outs[3] = o3;
  assign outs[4] = o4;   assign outs[5] = o5;   assign outs[6] = o6;   assign outs[7] = o7;
  assign outs[8] = o8;   assign outs[9] = o9;   assign outs[10] = o10; assign outs[11] = o11;
  assign outs[12] = o12; assign outs[13] = o13; assign outs[14] = o14; assign outs[15] = o15;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_valid();
    logic [15:0] v = 16'h0000;
    for (int i = 0; i < 16; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic bit model_ready(input int s);
    return !m_full[s] || out_ready[s];
  endfunction

  task automatic drive(input bit r, input bit v, input int s, input logic [31:0] d, input logic [15:0] rdy);
    rst_n = r; in_valid = v; sel = 4'(s); in_data = d; out_ready = rdy;
  endtask

  // One clock: check in_ready before the edge, advance the model, check all state after it.
  task automatic tick(input string tag);
    bit take;
    #1;
    if (model_known) chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, model_ready(int'(sel))});
    take = model_known && in_valid && model_ready(int'(sel));
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin m_data[i] = 32'd0; m_full[i] = 1'b0; end
      model_known = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (take && int'(sel) == i) begin m_data[i] = in_data; m_full[i] = 1'b1; end
        else if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
      end
    end
    @(negedge clk);
    if (model_known) begin
      chk({tag, ".out_valid"}, {16'd0, out_valid}, {16'd0, model_valid()});
      for (int i = 0; i < 16; i++) chk($sformatf("%s.out_%0d", tag, i), outs[i], m_data[i]);
    end
  endtask

  initial begin
    drive(1'b0, 1'b1, 3, 32'hDEAD_BEEF, 16'hFFFF);
    @(negedge clk);

    // Reset held for two cycles with a live input
    tick("reset0");
    tick("reset1");
    chk("reset.valid_zero", {16'd0, out_valid}, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

    // Sweep all lanes, consumers always ready
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, i, 32'(1000 * i), 16'hFFFF);
      tick("sweep");
      chk($sformatf("sweep.pulse_%0d", i), {16'd0, out_valid}, 32'(1) << i);
      chk($sformatf("sweep.data_%0d", i), outs[i], 32'(1000 * i));
    end
    drive(1'b1, 1'b0, 0, 32'd0, 16'hFFFF);
    tick("sweep_end");
    chk("sweep.drained", {16'd0, out_valid}, 32'd0);

    // Backpressure on lane 5
    drive(1'b1, 1'b1, 5, 32'hA5A5_A5A5, 16'hFFDF);
    tick("bp_load");
    drive(1'b1, 1'b1, 5, 32'h1234_5678, 16'hFFDF);
    #1 chk("bp.stall_ready", {31'd0, in_ready}, 32'd0);
    tick("bp_stall");
    chk("bp.held", o5, 32'hA5A5_A5A5);
    drive(1'b1, 1'b1, 5, 32'h1234_5678, 16'hFFFF);
    #1 chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
    tick("bp_release");
    chk("bp.new_word", o5, 32'h1234_5678);
    chk("bp.still_valid", {31'd0, out_valid[5]}, 32'd1);

    // Independent lanes: lane 2 stalled, lane 7 accepts
    drive(1'b1, 1'b1, 2, 32'd22, 16'h0000);
    tick("ind_load2");
    drive(1'b1, 1'b1, 7, 32'd77, 16'h0000);
    tick("ind_load7");
    chk("ind.out7", o7, 32'd77);
    chk("ind.out2", o2, 32'd22);

    // Fill every lane with consumers stalled
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, i, 32'(100 + i), 16'h0000);
      tick("fill");
    end
    chk("fill.all_valid", {16'd0, out_valid}, 32'h0000_FFFF);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, i, 32'd0, 16'h0000);
      #1 chk($sformatf("fill.ready_sel%0d", i), {31'd0, in_ready}, 32'd0);
    end
    drive(1'b1, 1'b0, 0, 32'd0, 16'h0200);
    tick("drain9");
    chk("drain9.valid", {16'd0, out_valid}, 32'h0000_FDFF);

    // Reset in the middle of a transfer
    drive(1'b0, 1'b0, 0, 32'd0, 16'h0000);
    tick("mid_clr");
    drive(1'b1, 1'b1, 0, 32'd10, 16'h0000);  tick("mid_l0");
    drive(1'b1, 1'b1, 4, 32'd40, 16'h0000);  tick("mid_l4");
    drive(1'b1, 1'b1, 15, 32'd150, 16'h0000); tick("mid_l15");
    drive(1'b0, 1'b1, 4, 32'd444, 16'h0010);
    tick("mid_rst");
    chk("mid.valid_zero", {16'd0, out_valid}, 32'd0);
    chk("mid.out4_zero", o4, 32'd0);
    chk("mid.out15_zero", o15, 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) != 0), 1'($urandom), int'($urandom_range(0, 15)),
            $urandom, 16'($urandom));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_demultiplexer_1to16_reg
